pwd_lock_ctrl: RTL and testbench
================================

// Module: pwd_lock_ctrl
// PURPOSE
// - Parametrised password-lock controller: N-digit code entry, attempt counting, timed lockout, in-field code change.
// - Sits between command decoder (UART/buttons) and display/LED logic; exposes state, lockout countdown, pulses.
// - Generalises the fixed 3-digit lock: code length, digit width, tries and lockout time are parameters.
// PARAMETERS
// - DIGIT_W    8          width of one code digit
// - CODE_LEN   3          digits per code (>=1)
// - MAX_TRIES  3          consecutive failed checks before lockout (>=1)
// - LOCK_TICKS 60         lockout duration in tick pulses (>=1)
// - INIT_CODE  0          reset code, CODE_LEN*DIGIT_W bits; digit 0 in LSBs
// PORTS
// - clk        in  1                      system clock
// - rst        in  1                      reset, asynchronous, active-high
// - tick       in  1                      1-cycle timebase pulse (e.g. 1 Hz)
// - cmd_start  in  1                      1-cycle: leave IDLE
// - cmd_check  in  1                      1-cycle: evaluate entry / commit new code
// - cmd_exit   in  1                      1-cycle: relock / abort code change
// - cmd_setpw  in  1                      1-cycle: enter code-change mode (OPEN only)
// - dig_valid  in  1                      1-cycle: dig carries one entered digit
// - dig        in  DIGIT_W                entered digit
// - state      out 3                      FSM state encoding (see BEHAVIOUR)
// - unlocked   out 1                      high in OPEN and SETPW
// - err_pulse  out 1                      1-cycle on each failed check
// - lock_pulse out 1                      1-cycle on entry to LOCKOUT
// - remain     out $clog2(LOCK_TICKS+1)   lockout ticks left; 0 outside LOCKOUT
// - fails      out $clog2(MAX_TRIES+1)    consecutive failed checks
// BEHAVIOUR
// - Reset: state=IDLE, code=INIT_CODE, all counters/flags 0, all outputs 0.
// - States: IDLE=0, ENTRY=1, ERR=2, LOCKOUT=3, OPEN=4, SETPW=5; others -> IDLE next cycle.
// - Command priority, same cycle: cmd_exit > cmd_check > cmd_setpw > dig_valid; lower ones ignored.
// - IDLE: cmd_start -> ENTRY; all else ignored.
// - ENTRY: dig_valid compares dig with code[idx]; idx++ saturating at CODE_LEN; mismatch or
//   digit beyond CODE_LEN sets sticky bad flag. cmd_check: match = (idx==CODE_LEN)&&!bad.
//   match -> OPEN, fails=0. fail -> fails++; if fails reaches MAX_TRIES -> LOCKOUT, else ERR.
//   Every cmd_check clears idx and bad. cmd_exit in ENTRY clears idx/bad, stays ENTRY.
// - ERR: exactly one cycle, err_pulse=1 registered with it, then ENTRY.
// - LOCKOUT: entry loads remain=LOCK_TICKS, err_pulse and lock_pulse both 1 for one cycle;
//   each tick decrements remain; transition when remain==1 and tick -> ENTRY, remain=0,
//   fails=0. All commands and digits ignored (including cmd_exit).
// - OPEN: cmd_exit -> ENTRY; cmd_setpw -> SETPW with idx=0; digits ignored.
// - SETPW: dig_valid writes shadow[idx], idx++ saturating; extra digits set bad.
//   cmd_check with idx==CODE_LEN && !bad: code<=shadow (same edge), -> OPEN. Otherwise
//   err_pulse, code unchanged, -> OPEN. cmd_exit: discard shadow -> OPEN.
// - All outputs registered; state change visible 1 cycle after the command cycle.
// - tick outside LOCKOUT ignored; tick and state entry same cycle: load wins, no decrement.
// - rst mid-operation: immediate return to reset values, including code=INIT_CODE.
// STRUCTURE
// - Shared package pwd_lock_pkg: state enum/localparams, command-priority constants.
// - Sub-module lock_timer: loadable down-counter (load, tick, remain, done); rest inline.
// - Code and shadow storage: flat registers CODE_LEN*DIGIT_W, indexed by idx.
// TESTING
// - Reset, cmd_start, digits 0,0,0, cmd_check (defaults) -> state OPEN in 1 cycle, unlocked=1, fails=0.
// - Digits 0,5,0, check -> err_pulse 1 cycle, ERR then ENTRY, fails=1; 4 digits 0,0,0,0 -> fails=2.
// - Third failure -> lock_pulse, remain=60; 60 ticks -> ENTRY, fails=0; cmds during lockout ignored.
// - OPEN, cmd_setpw, digits 1,2,3, check -> OPEN; exit; old code 0,0,0 now fails; 1,2,3 opens.
// - SETPW with 2 digits then check -> err_pulse, old code kept; cmd_exit+cmd_check same cycle -> exit wins.
// - rst asserted mid-LOCKOUT and mid-SETPW -> IDLE, remain=0, code=INIT_CODE.

Source files
------------

// File: rtl/pwd_lock_pkg.sv
// Shared types for the password-lock controller: FSM state encoding and
// same-cycle command arbitration.
package pwd_lock_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_ERR     = 3'd2,
        S_LOCKOUT = 3'd3,
        S_OPEN    = 3'd4,
        S_SETPW   = 3'd5
    } state_e;

    // Listed in falling priority after CMD_NONE
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_EXIT  = 3'd1,
        CMD_CHECK = 3'd2,
        CMD_SETPW = 3'd3,
        CMD_DIGIT = 3'd4
    } cmd_e;

    function automatic cmd_e decode_cmd(input logic exit_req, input logic check_req,
                                        input logic setpw_req, input logic digit_req);
        if (exit_req)       return CMD_EXIT;
        else if (check_req) return CMD_CHECK;
        else if (setpw_req) return CMD_SETPW;
        else if (digit_req) return CMD_DIGIT;
        else                return CMD_NONE;
    endfunction

endpackage

// File: rtl/pwd_lock_ctrl_if.sv
// Command/digit inputs and status outputs of the password-lock controller.
interface pwd_lock_ctrl_if #(
    parameter int DIGIT_W    = 8,
    parameter int MAX_TRIES  = 3,
    parameter int LOCK_TICKS = 60
);
    localparam int REM_W  = $clog2(LOCK_TICKS + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    logic               cmd_start;
    logic               cmd_check;
    logic               cmd_exit;
    logic               cmd_setpw;
    logic               dig_valid;
    logic [DIGIT_W-1:0] dig;
    logic [2:0]         state;
    logic               unlocked;
    logic               err_pulse;
    logic               lock_pulse;
    logic [REM_W-1:0]   remain;
    logic [FAIL_W-1:0]  fails;

    modport master (
        output cmd_start, cmd_check, cmd_exit, cmd_setpw, dig_valid, dig,
        input  state, unlocked, err_pulse, lock_pulse, remain, fails
    );

    modport slave (
        input  cmd_start, cmd_check, cmd_exit, cmd_setpw, dig_valid, dig,
        output state, unlocked, err_pulse, lock_pulse, remain, fails
    );

endinterface

// File: rtl/pwd_lock_ctrl_lock_timer.sv
// Loadable lockout down-counter; done flags the tick that takes remain from 1 to 0.
module lock_timer #(
    parameter int LOCK_TICKS = 60,
    parameter int REM_W      = $clog2(LOCK_TICKS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             tick,
    output logic [REM_W-1:0] remain,
    output logic             done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            remain <= '0;
        else if (load)
            remain <= REM_W'(LOCK_TICKS);
        else if (tick && (remain != '0))
            remain <= remain - REM_W'(1);
    end

    // Load has priority, so a tick coinciding with a reload never counts
    assign done = tick && !load && (remain == REM_W'(1));

endmodule

// File: rtl/pwd_lock_ctrl.sv
// Password-lock controller: N-digit code entry, failed-attempt counting,
// timed lockout and in-field code change. All outputs are registered.
module pwd_lock_ctrl
    import pwd_lock_pkg::*;
#(
    parameter int                          DIGIT_W    = 8,
    parameter int                          CODE_LEN   = 3,
    parameter int                          MAX_TRIES  = 3,
    parameter int                          LOCK_TICKS = 60,
    parameter logic [CODE_LEN*DIGIT_W-1:0] INIT_CODE  = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick,
    pwd_lock_ctrl_if.slave bus
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int IDX_W  = $clog2(CODE_LEN + 1);
    localparam int REM_W  = $clog2(LOCK_TICKS + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    state_e              state_q, state_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic                bad_q, bad_n;
    logic [FAIL_W-1:0]   fails_q, fails_n;
    logic [CODE_W-1:0]   code_q, code_n;
    logic [CODE_W-1:0]   shadow_q, shadow_n;
    logic                err_q, err_n;
    logic                lock_q, lock_n;
    logic                unlocked_q, unlocked_n;

    cmd_e                cmd;
    logic [DIGIT_W-1:0]  cur_digit;
    logic                idx_full;
    logic [FAIL_W-1:0]   fails_inc;
    logic                tmr_load;
    logic                tmr_done;
    logic [REM_W-1:0]    remain;

    assign cmd       = decode_cmd(bus.cmd_exit, bus.cmd_check, bus.cmd_setpw, bus.dig_valid);
    assign idx_full  = (idx_q == IDX_W'(CODE_LEN));
    assign fails_inc = fails_q + FAIL_W'(1);

    always_comb begin
        cur_digit = '0;
        for (int unsigned i = 0; i < CODE_LEN; i++) begin
            if (idx_q == IDX_W'(i))
                cur_digit = code_q[i*DIGIT_W +: DIGIT_W];
        end
    end

    lock_timer #(
        .LOCK_TICKS (LOCK_TICKS),
        .REM_W      (REM_W)
    ) u_lock_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .tick   (tick && (state_q == S_LOCKOUT)),
        .remain (remain),
        .done   (tmr_done)
    );

    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        bad_n    = bad_q;
        fails_n  = fails_q;
        code_n   = code_q;
        shadow_n = shadow_q;
        err_n    = 1'b0;
        lock_n   = 1'b0;
        tmr_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_start)
                    state_n = S_ENTRY;
            end

            S_ENTRY: begin
                case (cmd)
                    CMD_EXIT: begin
                        idx_n = '0;
                        bad_n = 1'b0;
                    end
                    CMD_CHECK: begin
                        idx_n = '0;
                        bad_n = 1'b0;
                        if (idx_full && !bad_q) begin
                            state_n = S_OPEN;
                            fails_n = '0;
                        end else begin
                            fails_n = fails_inc;
                            err_n   = 1'b1;
                            if (fails_inc == FAIL_W'(MAX_TRIES)) begin
                                state_n  = S_LOCKOUT;
                                lock_n   = 1'b1;
                                tmr_load = 1'b1;
                            end else begin
                                state_n = S_ERR;
                            end
                        end
                    end
                    CMD_DIGIT: begin
                        if (idx_full) begin
                            bad_n = 1'b1;
                        end else begin
                            if (bus.dig != cur_digit)
                                bad_n = 1'b1;
                            idx_n = idx_q + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end

            S_ERR: state_n = S_ENTRY;

            S_LOCKOUT: begin
                if (tmr_done) begin
                    state_n = S_ENTRY;
                    fails_n = '0;
                end
            end

            S_OPEN: begin
                case (cmd)
                    CMD_EXIT: state_n = S_ENTRY;
                    CMD_SETPW: begin
                        state_n = S_SETPW;
                        idx_n   = '0;
                        bad_n   = 1'b0;
                    end
                    default: ;
                endcase
            end

            S_SETPW: begin
                case (cmd)
                    CMD_EXIT: begin
                        state_n = S_OPEN;
                        idx_n   = '0;
                        bad_n   = 1'b0;
                    end
                    CMD_CHECK: begin
                        state_n = S_OPEN;
                        idx_n   = '0;
                        bad_n   = 1'b0;
                        if (idx_full && !bad_q)
                            code_n = shadow_q;
                        else
                            err_n = 1'b1;
                    end
                    CMD_DIGIT: begin
                        if (idx_full) begin
                            bad_n = 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < CODE_LEN; i++) begin
                                if (idx_q == IDX_W'(i))
                                    shadow_n[i*DIGIT_W +: DIGIT_W] = bus.dig;
                            end
                            idx_n = idx_q + IDX_W'(1);
                        end
                    end
                    default: ;
                endcase
            end

            default: begin
                state_n = S_IDLE;
                idx_n   = '0;
                bad_n   = 1'b0;
            end
        endcase
    end

    // unlocked is decoded from the next state so it lines up with state_q
    assign unlocked_n = (state_n == S_OPEN) || (state_n == S_SETPW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            bad_q      <= 1'b0;
            fails_q    <= '0;
            code_q     <= INIT_CODE;
            shadow_q   <= '0;
            err_q      <= 1'b0;
            lock_q     <= 1'b0;
            unlocked_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            idx_q      <= idx_n;
            bad_q      <= bad_n;
            fails_q    <= fails_n;
            code_q     <= code_n;
            shadow_q   <= shadow_n;
            err_q      <= err_n;
            lock_q     <= lock_n;
            unlocked_q <= unlocked_n;
        end
    end

    assign bus.state      = state_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.err_pulse  = err_q;
    assign bus.lock_pulse = lock_q;
    assign bus.remain     = remain;
    assign bus.fails      = fails_q;

endmodule

// File: tb/tb_pwd_lock_ctrl.sv
// Directed self-checking bench for pwd_lock_ctrl with default parameters.
module tb_pwd_lock_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    int   errors = 0;
    int   checks = 0;

    pwd_lock_ctrl_if #(.DIGIT_W(8), .MAX_TRIES(3), .LOCK_TICKS(60)) bus ();

    pwd_lock_ctrl #(
        .DIGIT_W    (8),
        .CODE_LEN   (3),
        .MAX_TRIES  (3),
        .LOCK_TICKS (60),
        .INIT_CODE  (24'h000000)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_cmd(input logic st, input logic ck, input logic ex, input logic sp);
        bus.cmd_start = st;
        bus.cmd_check = ck;
        bus.cmd_exit  = ex;
        bus.cmd_setpw = sp;
        cyc();
        bus.cmd_start = 1'b0;
        bus.cmd_check = 1'b0;
        bus.cmd_exit  = 1'b0;
        bus.cmd_setpw = 1'b0;
    endtask

    task automatic send_dig(input logic [7:0] d);
        bus.dig_valid = 1'b1;
        bus.dig       = d;
        cyc();
        bus.dig_valid = 1'b0;
        bus.dig       = '0;
    endtask

    task automatic send_code(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        send_dig(d0);
        send_dig(d1);
        send_dig(d2);
    endtask

    task automatic test_reset();
        bus.cmd_start = 0; bus.cmd_check = 0; bus.cmd_exit = 0; bus.cmd_setpw = 0;
        bus.dig_valid = 0; bus.dig = '0;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        checks++; if (bus.unlocked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.lock_pulse !== 1'b0)
            begin errors++; $display("FAIL reset_flags: got %b%b%b want 000", bus.unlocked, bus.err_pulse, bus.lock_pulse); end
        checks++; if (bus.remain !== 6'd0 || bus.fails !== 2'd0)
            begin errors++; $display("FAIL reset_counts: got remain=%0d fails=%0d want 0 0", bus.remain, bus.fails); end
        // Commands other than start are ignored in IDLE
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_ignore: got %0d want 0", bus.state); end
    endtask

    task automatic test_open_default();
        pulse_cmd(1, 0, 0, 0);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL start_entry: got %0d want 1", bus.state); end
        send_code(8'd0, 8'd0, 8'd0);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL open_state: got %0d want 4", bus.state); end
        checks++; if (bus.unlocked !== 1'b1 || bus.fails !== 2'd0)
            begin errors++; $display("FAIL open_flags: got unlocked=%b fails=%0d want 1 0", bus.unlocked, bus.fails); end
        pulse_cmd(0, 0, 1, 0);
        checks++; if (bus.state !== 3'd1 || bus.unlocked !== 1'b0)
            begin errors++; $display("FAIL open_exit: got state=%0d unlocked=%b want 1 0", bus.state, bus.unlocked); end
    endtask

    task automatic test_wrong_code();
        send_code(8'd0, 8'd5, 8'd0);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd2 || bus.err_pulse !== 1'b1 || bus.fails !== 2'd1)
            begin errors++; $display("FAIL wrong1: got state=%0d err=%b fails=%0d want 2 1 1", bus.state, bus.err_pulse, bus.fails); end
        cyc();
        checks++; if (bus.state !== 3'd1 || bus.err_pulse !== 1'b0)
            begin errors++; $display("FAIL err_one_cycle: got state=%0d err=%b want 1 0", bus.state, bus.err_pulse); end
        send_code(8'd0, 8'd0, 8'd0);
        send_dig(8'd0);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd2 || bus.fails !== 2'd2)
            begin errors++; $display("FAIL extra_digit: got state=%0d fails=%0d want 2 2", bus.state, bus.fails); end
        cyc();
    endtask

    task automatic test_lockout();
        send_dig(8'd9);
        tick = 1'b1;
        pulse_cmd(0, 1, 0, 0);
        tick = 1'b0;
        checks++; if (bus.state !== 3'd3 || bus.remain !== 6'd60)
            begin errors++; $display("FAIL lock_enter: got state=%0d remain=%0d want 3 60", bus.state, bus.remain); end
        checks++; if (bus.err_pulse !== 1'b1 || bus.lock_pulse !== 1'b1 || bus.fails !== 2'd3)
            begin errors++; $display("FAIL lock_pulses: got err=%b lock=%b fails=%0d want 1 1 3", bus.err_pulse, bus.lock_pulse, bus.fails); end
        cyc();
        checks++; if (bus.err_pulse !== 1'b0 || bus.lock_pulse !== 1'b0)
            begin errors++; $display("FAIL lock_pulse_len: got err=%b lock=%b want 0 0", bus.err_pulse, bus.lock_pulse); end
        pulse_cmd(0, 0, 1, 0);
        pulse_cmd(0, 1, 0, 0);
        pulse_cmd(1, 0, 0, 1);
        send_code(8'd0, 8'd0, 8'd0);
        checks++; if (bus.state !== 3'd3 || bus.remain !== 6'd60 || bus.unlocked !== 1'b0)
            begin errors++; $display("FAIL lock_ignore: got state=%0d remain=%0d want 3 60", bus.state, bus.remain); end
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++; if (bus.remain !== 6'd59) begin errors++; $display("FAIL lock_dec: got %0d want 59", bus.remain); end
        for (int i = 0; i < 58; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0; cyc();
        end
        checks++; if (bus.state !== 3'd3 || bus.remain !== 6'd1)
            begin errors++; $display("FAIL lock_last: got state=%0d remain=%0d want 3 1", bus.state, bus.remain); end
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++; if (bus.state !== 3'd1 || bus.remain !== 6'd0 || bus.fails !== 2'd0)
            begin errors++; $display("FAIL lock_exit: got state=%0d remain=%0d fails=%0d want 1 0 0", bus.state, bus.remain, bus.fails); end
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++; if (bus.remain !== 6'd0) begin errors++; $display("FAIL tick_outside: got %0d want 0", bus.remain); end
    endtask

    task automatic test_setpw();
        send_code(8'd0, 8'd0, 8'd0);
        pulse_cmd(0, 1, 0, 0);
        pulse_cmd(0, 0, 0, 1);
        checks++; if (bus.state !== 3'd5 || bus.unlocked !== 1'b1)
            begin errors++; $display("FAIL setpw_enter: got state=%0d unlocked=%b want 5 1", bus.state, bus.unlocked); end
        send_code(8'd1, 8'd2, 8'd3);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd4 || bus.err_pulse !== 1'b0)
            begin errors++; $display("FAIL setpw_commit: got state=%0d err=%b want 4 0", bus.state, bus.err_pulse); end
        pulse_cmd(0, 0, 1, 0);
        send_code(8'd0, 8'd0, 8'd0);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd2 || bus.fails !== 2'd1)
            begin errors++; $display("FAIL old_code: got state=%0d fails=%0d want 2 1", bus.state, bus.fails); end
        cyc();
        send_code(8'd1, 8'd2, 8'd3);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd4 || bus.fails !== 2'd0)
            begin errors++; $display("FAIL new_code: got state=%0d fails=%0d want 4 0", bus.state, bus.fails); end
    endtask

    task automatic test_setpw_short();
        pulse_cmd(0, 0, 0, 1);
        send_dig(8'd7);
        send_dig(8'd7);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd4 || bus.err_pulse !== 1'b1)
            begin errors++; $display("FAIL short_setpw: got state=%0d err=%b want 4 1", bus.state, bus.err_pulse); end
        cyc();
        pulse_cmd(0, 0, 0, 1);
        send_code(8'd4, 8'd4, 8'd4);
        pulse_cmd(0, 1, 1, 0);
        checks++; if (bus.state !== 3'd4 || bus.err_pulse !== 1'b0)
            begin errors++; $display("FAIL setpw_abort: got state=%0d err=%b want 4 0", bus.state, bus.err_pulse); end
        pulse_cmd(0, 0, 1, 0);
        send_code(8'd1, 8'd2, 8'd3);
        pulse_cmd(0, 1, 1, 0);
        checks++; if (bus.state !== 3'd1 || bus.err_pulse !== 1'b0)
            begin errors++; $display("FAIL exit_wins: got state=%0d err=%b want 1 0", bus.state, bus.err_pulse); end
        send_code(8'd1, 8'd2, 8'd3);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL code_kept: got %0d want 4", bus.state); end
        pulse_cmd(0, 0, 1, 0);
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) begin
            send_dig(8'd9);
            pulse_cmd(0, 1, 0, 0);
            if (i < 2) cyc();
        end
        tick = 1'b1; cyc(); tick = 1'b0;
        checks++; if (bus.state !== 3'd3 || bus.remain !== 6'd59)
            begin errors++; $display("FAIL pre_rst_lock: got state=%0d remain=%0d want 3 59", bus.state, bus.remain); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.state !== 3'd0 || bus.remain !== 6'd0 || bus.fails !== 2'd0)
            begin errors++; $display("FAIL rst_lock: got state=%0d remain=%0d fails=%0d want 0 0 0", bus.state, bus.remain, bus.fails); end
        cyc();
        rst = 1'b0;
        pulse_cmd(1, 0, 0, 0);
        send_code(8'd0, 8'd0, 8'd0);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL rst_code1: got %0d want 4", bus.state); end
        pulse_cmd(0, 0, 0, 1);
        send_code(8'd5, 8'd5, 8'd5);
        pulse_cmd(0, 1, 0, 0);
        pulse_cmd(0, 0, 0, 1);
        send_dig(8'd6);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.state !== 3'd0 || bus.unlocked !== 1'b0)
            begin errors++; $display("FAIL rst_setpw: got state=%0d unlocked=%b want 0 0", bus.state, bus.unlocked); end
        cyc();
        rst = 1'b0;
        pulse_cmd(1, 0, 0, 0);
        send_code(8'd0, 8'd0, 8'd0);
        pulse_cmd(0, 1, 0, 0);
        checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL rst_code2: got %0d want 4", bus.state); end
    endtask

    initial begin
        test_reset();
        test_open_default();
        test_wrong_code();
        test_lockout();
        test_setpw();
        test_setpw_short();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
